// File: rtl/tcdm_rr_arbiter.sv
// tcdm_rr_arbiter: shares one TCDM port among NB_REQ requesters using round-robin
// arbitration. An in-order ID FIFO records who issued each accepted transaction,
// so each returning response is steered back to the requester that issued it.
module tcdm_rr_arbiter #(
   parameter int NB_REQ  = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MAX_OUT = 4,
   localparam int ID_W   = $clog2(NB_REQ),
   localparam int OCC_W  = $clog2(MAX_OUT + 1),
   localparam int BE_W   = DATA_W / 8
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           clear_i,
   input  logic [NB_REQ-1:0]              in_req_i,
   output logic [NB_REQ-1:0]              in_gnt_o,
   input  logic [NB_REQ-1:0][ADDR_W-1:0]  in_add_i,
   input  logic [NB_REQ-1:0]              in_wen_i,
   input  logic [NB_REQ-1:0][BE_W-1:0]    in_be_i,
   input  logic [NB_REQ-1:0][DATA_W-1:0]  in_data_i,
   output logic [NB_REQ-1:0][DATA_W-1:0]  in_r_data_o,
   output logic [NB_REQ-1:0]              in_r_valid_o,
   output logic                           out_req_o,
   input  logic                           out_gnt_i,
   output logic [ADDR_W-1:0]              out_add_o,
   output logic                           out_wen_o,
   output logic [BE_W-1:0]                out_be_o,
   output logic [DATA_W-1:0]              out_data_o,
   input  logic [DATA_W-1:0]              out_r_data_i,
   input  logic                           out_r_valid_i,
   output logic [OCC_W-1:0]               outstanding_o,
   output logic                           err_o
);

   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   logic [ID_W-1:0]  prio_q;
   logic [ID_W-1:0]  fifo_q [MAX_OUT];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [OCC_W-1:0] occ_q;
   logic             err_q;

   logic [ID_W-1:0]  winner;
   logic             any_req;
   logic             full;
   logic             push;
   logic             pop;
   logic             orphan;
   logic [ID_W-1:0]  head_id;

   // FIFO pointers wrap explicitly so MAX_OUT need not be a power of two
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Scan upward from the priority pointer; the first active request wins
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      for (int i = 0; i < NB_REQ; i++) begin
         if (!any_req && in_req_i[ID_W'((int'(prio_q) + i) % NB_REQ)]) begin
            any_req = 1'b1;
            winner  = ID_W'((int'(prio_q) + i) % NB_REQ);
         end
      end
   end

   // Full uses only the registered occupancy, so a same-cycle pop never frees a slot early
   assign full      = (occ_q == OCC_W'(MAX_OUT));
   assign out_req_o = any_req & ~full;
   assign push      = out_req_o & out_gnt_i;
   assign pop       = out_r_valid_i & (occ_q != '0);
   assign orphan    = out_r_valid_i & (occ_q == '0);
   assign head_id   = fifo_q[rd_ptr_q];

   // Forward the winner's payload downstream; zero when nothing is requested
   always_comb begin
      out_add_o  = '0;
      out_wen_o  = 1'b0;
      out_be_o   = '0;
      out_data_o = '0;
      if (out_req_o) begin
         out_add_o  = in_add_i[winner];
         out_wen_o  = in_wen_i[winner];
         out_be_o   = in_be_i[winner];
         out_data_o = in_data_i[winner];
      end
   end

   // Grant only the winner, directly from the downstream grant
   always_comb begin
      in_gnt_o = '0;
      if (push) begin
         in_gnt_o[winner] = 1'b1;
      end
   end

   // Steer the response valid to the requester at the head of the ID FIFO
   always_comb begin
      in_r_valid_o = '0;
      if (pop) begin
         in_r_valid_o[head_id] = 1'b1;
      end
   end

   assign in_r_data_o   = {NB_REQ{out_r_data_i}};
   assign outstanding_o = occ_q;
   assign err_o         = err_q;

   // Priority pointer, ID FIFO, occupancy and sticky error; clear behaves like reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < MAX_OUT; i++) begin
            fifo_q[i] <= '0;
         end
      end else if (clear_i) begin
         prio_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= winner;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
            prio_q           <= (winner == ID_W'(NB_REQ - 1)) ? '0 : winner + ID_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (push && !pop) begin
            occ_q <= occ_q + OCC_W'(1);
         end else if (pop && !push) begin
            occ_q <= occ_q - OCC_W'(1);
         end
         if (orphan) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// tb_tcdm_rr_arbiter: directed scenarios followed by randomized traffic, all checked
// against a queue-based reference model of arbitration, ID ordering and memory contents.
module tb_tcdm_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MO = 4;
   localparam int OW = $clog2(MO + 1);

   logic                    clk_i = 1'b0;
   logic                    rst_ni;
   logic                    clear_i;
   logic [N-1:0]            in_req_i;
   logic [N-1:0]            in_gnt_o;
   logic [N-1:0][AW-1:0]    in_add_i;
   logic [N-1:0]            in_wen_i;
   logic [N-1:0][BW-1:0]    in_be_i;
   logic [N-1:0][DW-1:0]    in_data_i;
   logic [N-1:0][DW-1:0]    in_r_data_o;
   logic [N-1:0]            in_r_valid_o;
   logic                    out_req_o;
   logic                    out_gnt_i;
   logic [AW-1:0]           out_add_o;
   logic                    out_wen_o;
   logic [BW-1:0]           out_be_o;
   logic [DW-1:0]           out_data_o;
   logic [DW-1:0]           out_r_data_i;
   logic                    out_r_valid_i;
   logic [OW-1:0]           outstanding_o;
   logic                    err_o;

   tcdm_rr_arbiter #(
      .NB_REQ (N),
      .ADDR_W (AW),
      .DATA_W (DW),
      .MAX_OUT(MO)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .in_req_i     (in_req_i),
      .in_gnt_o     (in_gnt_o),
      .in_add_i     (in_add_i),
      .in_wen_i     (in_wen_i),
      .in_be_i      (in_be_i),
      .in_data_i    (in_data_i),
      .in_r_data_o  (in_r_data_o),
      .in_r_valid_o (in_r_valid_o),
      .out_req_o    (out_req_o),
      .out_gnt_i    (out_gnt_i),
      .out_add_o    (out_add_o),
      .out_wen_o    (out_wen_o),
      .out_be_o     (out_be_o),
      .out_data_o   (out_data_o),
      .out_r_data_i (out_r_data_i),
      .out_r_valid_i(out_r_valid_i),
      .outstanding_o(outstanding_o),
      .err_o        (err_o)
   );

   // Free-running clock, period 10
   always #5 clk_i = ~clk_i;

   typedef struct {
      int            id;
      bit            rd;
      logic [DW-1:0] data;
   } txn_t;

   txn_t          mq[$];
   int            m_prio;
   bit            m_err;
   logic [DW-1:0] mem [16];

   int n_tests = 0;
   int n_fail  = 0;
   int req_pct, gnt_pct, rsp_pct, orphan_pct, clear_pct;
   bit do_orphan;

   int            obs_gnt[$];
   int            obs_rv[$];
   logic [N-1:0]  obs_gvec[$];
   logic [AW-1:0] obs_add[$];
   logic [DW-1:0] obs_rdata[$];

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic newRequest(input int p);
      in_req_i[p]  = 1'b1;
      in_add_i[p]  = AW'($urandom_range(15)) << 2;
      in_wen_i[p]  = 1'($urandom_range(1));
      in_be_i[p]   = BW'($urandom);
      in_data_i[p] = $urandom;
   endtask

   // Requesters raise new requests, the memory grants and answers at random rates
   task automatic applyStimulus();
      for (int p = 0; p < N; p++) begin
         if (!in_req_i[p] && $urandom_range(99) < req_pct) newRequest(p);
      end
      out_gnt_i     = ($urandom_range(99) < gnt_pct);
      out_r_data_i  = $urandom;
      out_r_valid_i = 1'b0;
      if (mq.size() > 0) begin
         if ($urandom_range(99) < rsp_pct) begin
            out_r_valid_i = 1'b1;
            out_r_data_i  = mq[0].data;
         end
      end else if (do_orphan || $urandom_range(99) < orphan_pct) begin
         out_r_valid_i = 1'b1;
      end
      clear_i = ($urandom_range(99) < clear_pct);
   endtask

   // One clock: drive, check against the model at negedge, advance the model at posedge
   task automatic runCycle();
      int                      w;
      int                      idx;
      bit                      e_req, e_push, e_pop, e_orph;
      logic [N-1:0]            e_gnt, e_rv;
      logic [AW+1+BW+DW-1:0]   e_pay;
      txn_t                    t;
      applyStimulus();
      @(negedge clk_i);
      w = -1;
      for (int i = 0; i < N; i++) begin
         if (w < 0 && in_req_i[(m_prio + i) % N]) w = (m_prio + i) % N;
      end
      e_req  = (w >= 0) && (mq.size() < MO);
      e_push = e_req && out_gnt_i;
      e_pop  = out_r_valid_i && (mq.size() > 0);
      e_orph = out_r_valid_i && (mq.size() == 0);
      e_gnt  = '0;
      if (e_push) e_gnt[w] = 1'b1;
      e_rv = '0;
      if (e_pop) e_rv[mq[0].id] = 1'b1;
      e_pay = '0;
      if (e_req) e_pay = {in_add_i[w], in_wen_i[w], in_be_i[w], in_data_i[w]};
      checkOutput("out_req", 128'(out_req_o), 128'(e_req));
      checkOutput("in_gnt", 128'(in_gnt_o), 128'(e_gnt));
      checkOutput("payload", 128'({out_add_o, out_wen_o, out_be_o, out_data_o}), 128'(e_pay));
      checkOutput("r_valid", 128'(in_r_valid_o), 128'(e_rv));
      checkOutput("outstanding", 128'(outstanding_o), 128'(mq.size()));
      checkOutput("err", 128'(err_o), 128'(m_err));
      if (e_pop && mq[0].rd) checkOutput("r_data", 128'(in_r_data_o[mq[0].id]), 128'(mq[0].data));
      for (int p = 0; p < N; p++) begin
         if (in_gnt_o[p]) obs_gnt.push_back(p);
         if (in_r_valid_o[p]) begin
            obs_rv.push_back(p);
            obs_rdata.push_back(in_r_data_o[p]);
         end
      end
      obs_gvec.push_back(in_gnt_o);
      obs_add.push_back(out_add_o);
      @(posedge clk_i);
      if (clear_i) begin
         mq.delete();
         m_prio = 0;
         m_err  = 1'b0;
      end else begin
         if (e_pop) mq.delete(0);
         if (e_orph) m_err = 1'b1;
         if (e_push) begin
            idx    = int'(in_add_i[w][5:2]);
            t.id   = w;
            t.rd   = in_wen_i[w];
            t.data = t.rd ? mem[idx] : $urandom;
            if (!t.rd) begin
               for (int b = 0; b < BW; b++) begin
                  if (in_be_i[w][b]) mem[idx][8*b +: 8] = in_data_i[w][8*b +: 8];
               end
            end
            mq.push_back(t);
            m_prio = (w + 1) % N;
         end
      end
      #1;
      if (e_push) in_req_i[w] = 1'b0;
   endtask

   // Let pending requests and responses complete, bounded by a cycle budget
   task automatic drain();
      int n;
      n = 0;
      req_pct = 0; gnt_pct = 100; rsp_pct = 100; orphan_pct = 0; clear_pct = 0;
      while ((in_req_i != '0 || mq.size() > 0) && n < 100) begin
         runCycle();
         n++;
      end
      checkOutput("drain_timeout", 128'(n < 100), 128'(1));
   endtask

   // Asynchronous reset: occupancy must drop without waiting for a clock edge
   task automatic doReset();
      rst_ni = 1'b0;
      in_req_i = '0; out_r_valid_i = 1'b0; out_gnt_i = 1'b0; clear_i = 1'b0;
      #1;
      checkOutput("rst_outstanding", 128'(outstanding_o), 128'(0));
      checkOutput("rst_out_req", 128'(out_req_o), 128'(0));
      mq.delete();
      m_prio = 0;
      m_err  = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   // Watchdog so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios, then randomized traffic
   initial begin
      int            p0;
      int            got;
      logic [DW-1:0] prior;
      rst_ni = 1'b1; clear_i = 1'b0; in_req_i = '0; in_add_i = '0; in_wen_i = '0;
      in_be_i = '0; in_data_i = '0; out_gnt_i = 1'b0; out_r_data_i = '0; out_r_valid_i = 1'b0;
      do_orphan = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      #2 doReset();

      req_pct = 0; gnt_pct = 0; rsp_pct = 0; orphan_pct = 0; clear_pct = 0;
      repeat (2) runCycle();

      // All requesters busy with full grant: strict rotation 0,1,2,3,...
      obs_gnt.delete(); obs_rv.delete();
      req_pct = 100; gnt_pct = 100; rsp_pct = 100;
      repeat (8) runCycle();
      for (int k = 0; k < 8; k++) begin
         got = (k < obs_gnt.size()) ? obs_gnt[k] : 99;
         checkOutput($sformatf("rr_gnt%0d", k), 128'(got), 128'(k % 4));
      end
      for (int k = 0; k < 7; k++) begin
         got = (k < obs_rv.size()) ? obs_rv[k] : 99;
         checkOutput($sformatf("rr_rv%0d", k), 128'(got), 128'(k % 4));
      end

      // Lone requester stalled for three cycles keeps its request and address on the bus
      drain();
      req_pct = 0; rsp_pct = 0;
      in_req_i[2] = 1'b1; in_add_i[2] = 32'h20; in_wen_i[2] = 1'b1; in_be_i[2] = '1; in_data_i[2] = '0;
      obs_gvec.delete(); obs_add.delete();
      gnt_pct = 0;
      repeat (3) runCycle();
      gnt_pct = 100;
      runCycle();
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("stall_gnt%0d", k), 128'(obs_gvec[k]), 128'((k == 3) ? 4'b0100 : 4'b0000));
         checkOutput($sformatf("stall_add%0d", k), 128'(obs_add[k]), 128'(32'h20));
      end

      // Withheld responses fill the FIFO; releasing them returns IDs in grant order
      drain();
      p0 = m_prio;
      obs_gnt.delete();
      req_pct = 100; gnt_pct = 100; rsp_pct = 0;
      repeat (6) runCycle();
      checkOutput("full_ngnt", 128'(obs_gnt.size()), 128'(4));
      checkOutput("full_outstanding", 128'(outstanding_o), 128'(4));
      checkOutput("full_out_req", 128'(out_req_o), 128'(0));
      obs_rv.delete(); obs_gvec.delete();
      rsp_pct = 100;
      repeat (5) runCycle();
      for (int k = 0; k < 4; k++) begin
         got = (k < obs_rv.size()) ? obs_rv[k] : 99;
         checkOutput($sformatf("full_rv%0d", k), 128'(got), 128'((p0 + k) % 4));
      end
      checkOutput("full_no_bypass", 128'(obs_gvec[0]), 128'(0));
      checkOutput("full_refill", 128'(obs_gvec[1] != '0), 128'(1));

      // Partial write by port 1 then read back by port 3
      drain();
      req_pct = 0; gnt_pct = 100; rsp_pct = 100;
      prior = mem[4];
      in_req_i[1] = 1'b1; in_add_i[1] = 32'h10; in_wen_i[1] = 1'b0; in_be_i[1] = 4'b0011; in_data_i[1] = 32'hDEADBEEF;
      obs_rv.delete(); obs_rdata.delete();
      runCycle();
      in_req_i[3] = 1'b1; in_add_i[3] = 32'h10; in_wen_i[3] = 1'b1; in_be_i[3] = 4'hF; in_data_i[3] = '0;
      repeat (3) runCycle();
      checkOutput("wr_rd_count", 128'(obs_rv.size()), 128'(2));
      got = (obs_rv.size() > 0) ? obs_rv[0] : 99;
      checkOutput("wr_rv_port", 128'(got), 128'(1));
      got = (obs_rv.size() > 1) ? obs_rv[1] : 99;
      checkOutput("rd_rv_port", 128'(got), 128'(3));
      checkOutput("rd_data", 128'((obs_rdata.size() > 1) ? obs_rdata[1] : 32'h0), 128'({prior[31:16], 16'hBEEF}));

      // Orphan response sets the sticky error; clear resets it and the pointer
      drain();
      obs_rv.delete();
      do_orphan = 1'b1;
      runCycle();
      do_orphan = 1'b0;
      repeat (2) runCycle();
      checkOutput("orphan_rv", 128'(obs_rv.size()), 128'(0));
      checkOutput("err_sticky", 128'(err_o), 128'(1));
      clear_pct = 100;
      runCycle();
      clear_pct = 0;
      checkOutput("clear_err", 128'(err_o), 128'(0));
      checkOutput("clear_outstanding", 128'(outstanding_o), 128'(0));
      obs_gnt.delete();
      req_pct = 100;
      runCycle();
      got = (obs_gnt.size() > 0) ? obs_gnt[0] : 99;
      checkOutput("clear_first_gnt", 128'(got), 128'(0));

      // Reset with three transactions in flight
      drain();
      req_pct = 100; gnt_pct = 100; rsp_pct = 0;
      repeat (3) runCycle();
      checkOutput("pre_rst_outstanding", 128'(outstanding_o), 128'(3));
      doReset();
      obs_gnt.delete();
      req_pct = 100; gnt_pct = 100; rsp_pct = 100;
      runCycle();
      got = (obs_gnt.size() > 0) ? obs_gnt[0] : 99;
      checkOutput("rst_first_gnt", 128'(got), 128'(0));

      // Randomized traffic in blocks with varying rates
      drain();
      for (int blk = 0; blk < 30; blk++) begin
         req_pct    = int'($urandom_range(100));
         gnt_pct    = int'($urandom_range(100));
         rsp_pct    = int'($urandom_range(100));
         orphan_pct = int'($urandom_range(2));
         clear_pct  = (blk % 5 == 4) ? 2 : 0;
         repeat (100) runCycle();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
